nibble_add_unit: RTL and testbench

- Unsigned adder: two WIDTH-bit operands produce a (WIDTH+1)-bit sum with no truncation.
- The sum output is purely combinational, with zero latency.
- A registered copy of the result, a carry flag and a valid flag are provided for downstream clocked logic in the datapath.
- One clock; reset is asynchronous and active-high.

---
 rtl/nibble_add_unit.sv | 85 ++++++++
 tb/tb_nibble_add_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add_unit
//  Description : Unsigned WIDTH-bit ripple-carry adder with a zero-latency
//                (WIDTH+1)-bit sum/carry output, plus registered sum, carry
//                and valid outputs. Optional saturating carry-event counter
//                enabled with macro NIBBLE_ADD_CARRY_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             en,
    output logic [WIDTH:0]   sum,
    output logic             cout,
    output logic [WIDTH:0]   sum_q,
    output logic             cout_q,
    output logic             valid_q,
    output logic [7:0]       carry_cnt
);

    // Carry chain: w_c[i] is the carry into bit i; w_c[0] is tied low.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    logic [WIDTH:0]   r_sum_q;
    logic             r_cout_q;
    logic             r_valid_q;

    assign w_c[0] = 1'b0;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            // Full-adder cell: sum bit is the 3-input XOR, carry is majority.
            assign w_s[i]   = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
        end
    endgenerate

    // Final carry becomes the top sum bit, so the result never wraps.
    assign sum  = {w_c[WIDTH], w_s};
    assign cout = w_c[WIDTH];

    // Capture sum/carry when enabled; valid tracks the enable one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            if (en) begin
                r_sum_q  <= sum;
                r_cout_q <= cout;
            end
            r_valid_q <= en;
        end
    end

    assign sum_q   = r_sum_q;
    assign cout_q  = r_cout_q;
    assign valid_q = r_valid_q;

`ifdef NIBBLE_ADD_CARRY_CNT_EN
    logic [7:0] r_carry_cnt;

    // Count enabled cycles that produce a carry, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_cnt <= 8'h00;
        end else if (en && cout && (r_carry_cnt != 8'hFF)) begin
            r_carry_cnt <= r_carry_cnt + 8'h01;
        end
    end

    assign carry_cnt = r_carry_cnt;
`else
    assign carry_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_add_unit
//  Description : Directed self-checking bench for nibble_add_unit.
//                Honors NIBBLE_ADD_CARRY_CNT_EN for the counter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_add_unit;

    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic [3:0] y;
    logic       en;
    logic [4:0] sum;
    logic       cout;
    logic [4:0] sum_q;
    logic       cout_q;
    logic       valid_q;
    logic [7:0] carry_cnt;

    int n_cmp = 0;
    int n_err = 0;

    nibble_add_unit #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .en        (en),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .valid_q   (valid_q),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        en  = 1'b0;
        x   = 4'h0;
        y   = 4'h0;
        #2;
        // Reset state, before any clock edge
        chk("rst_sum_q",   sum_q,     32'h0);
        chk("rst_cout_q",  cout_q,    32'h0);
        chk("rst_valid_q", valid_q,   32'h0);
        chk("rst_cnt",     carry_cnt, 32'h0);
        chk("rst_comb_sum", sum,      32'h0);

        step();
        rst = 1'b0;

        // Directed combinational vectors
        x = 4'hF; y = 4'hF; en = 1'b1; #1;
        chk("ff_sum",  sum,  32'h1E);
        chk("ff_cout", cout, 32'h1);
        step();
        chk("ff_sum_q",   sum_q,   32'h1E);
        chk("ff_cout_q",  cout_q,  32'h1);
        chk("ff_valid_q", valid_q, 32'h1);
        en = 1'b0;
        x = 4'h0; y = 4'h0; #1;
        chk("00_sum",  sum,  32'h00);
        chk("00_cout", cout, 32'h0);
        x = 4'h8; y = 4'h8; #1;
        chk("88_sum",  sum,  32'h10);
        chk("88_cout", cout, 32'h1);
        x = 4'h7; y = 4'h8; #1;
        chk("78_sum",  sum,  32'h0F);
        chk("78_cout", cout, 32'h0);
        step();
        chk("en0_valid_q", valid_q, 32'h0);
        chk("en0_hold_sum_q", sum_q, 32'h1E);

        // Random sweep, inputs changed on both clock edges
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) @(posedge clk);
            else            @(negedge clk);
            v = $urandom;
            {x, y} = v[7:0];
            #1;
            chk("rnd_sum",  sum,  32'({1'b0, x} + {1'b0, y}));
            chk("rnd_cout", cout, 32'(({1'b0, x} + {1'b0, y}) >> 4));
        end

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                x = a[3:0];
                y = b[3:0];
                #1;
                chk("exh_sum",  sum,  32'(a + b));
                chk("exh_cout", cout, 32'((a + b) >= 16));
            end
        end

        // Hold check
        @(negedge clk);
        x = 4'h3; y = 4'h4; en = 1'b1;
        step();
        chk("hold_cap_sum_q", sum_q,   32'h07);
        chk("hold_cap_valid", valid_q, 32'h1);
        en = 1'b0; x = 4'h9; y = 4'h9; #1;
        chk("hold_comb_sum", sum, 32'h12);
        chk("hold_comb_cout", cout, 32'h1);
        step();
        chk("hold_sum_q",   sum_q,   32'h07);
        chk("hold_cout_q",  cout_q,  32'h0);
        chk("hold_valid_q", valid_q, 32'h0);

        // Reset mid-run
        x = 4'hF; y = 4'hF; en = 1'b1;
        step();
        chk("pre_rst_sum_q", sum_q, 32'h1E);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_sum_q",   sum_q,     32'h0);
        chk("mid_rst_cout_q",  cout_q,    32'h0);
        chk("mid_rst_valid_q", valid_q,   32'h0);
        chk("mid_rst_cnt",     carry_cnt, 32'h0);
        chk("mid_rst_sum",     sum,       32'h1E);
        step();
        chk("rst_en_sum_q",   sum_q,   32'h0);
        chk("rst_en_valid_q", valid_q, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_sum_q",   sum_q,   32'h1E);
        chk("post_rst_cout_q",  cout_q,  32'h1);
        chk("post_rst_valid_q", valid_q, 32'h1);

        // Carry counter
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        x = 4'hF; y = 4'h1; en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("sum_q_f1", sum_q, 32'h10);
`ifdef NIBBLE_ADD_CARRY_CNT_EN
        chk("cnt_10", carry_cnt, 32'd10);
`else
        chk("cnt_off_10", carry_cnt, 32'h0);
`endif
        for (int i = 0; i < 290; i++) step();
`ifdef NIBBLE_ADD_CARRY_CNT_EN
        chk("cnt_sat", carry_cnt, 32'hFF);
`else
        chk("cnt_off_300", carry_cnt, 32'h0);
`endif
        // No carry: counter must not move
        x = 4'h1; y = 4'h2;
        step();
`ifdef NIBBLE_ADD_CARRY_CNT_EN
        chk("cnt_nocarry", carry_cnt, 32'hFF);
`else
        chk("cnt_off_nocarry", carry_cnt, 32'h0);
`endif
        chk("cap_sum_q_03", sum_q, 32'h03);
        chk("cap_cout_q_0", cout_q, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
